// File: rtl/sudoku_pkg.sv
// Shared constants for the Sudoku engine: top-FSM state codes and default geometry.
package sudoku_pkg;

    typedef enum logic [2:0] {
        ST_CARREGANDO        = 3'b010,
        ST_PERCORRER_NUMEROS = 3'b100
    } top_state_e;

    localparam int unsigned N_DEF           = 9;
    localparam int unsigned DW_DEF          = 4;
    localparam int unsigned IW_DEF          = 7;
    localparam int unsigned MAX_STRIKES_DEF = 3;

endpackage

// File: rtl/board_updater_ext_popcount.sv
// Combinational population count built as a recursive binary adder tree.
module popcount #(
    parameter  int unsigned W  = 8,
    localparam int unsigned OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_i,
    output logic [OW-1:0] count_o
);

    if (W == 1) begin : g_leaf
        assign count_o = bits_i;
    end else begin : g_node
        localparam int unsigned LW  = W / 2;
        localparam int unsigned RW  = W - LW;
        localparam int unsigned LOW = $clog2(LW + 1);
        localparam int unsigned ROW = $clog2(RW + 1);

        logic [LOW-1:0] lo_count;
        logic [ROW-1:0] hi_count;

        popcount #(.W(LW)) u_lo (
            .bits_i  (bits_i[LW-1:0]),
            .count_o (lo_count)
        );

        popcount #(.W(RW)) u_hi (
            .bits_i  (bits_i[W-1:LW]),
            .count_o (hi_count)
        );

        assign count_o = OW'(lo_count) + OW'(hi_count);
    end

endmodule

// File: rtl/board_updater_ext.sv
// Live Sudoku board state: visibility, notes, strikes, digit selection and win/lose flags.
module board_updater_ext
    import sudoku_pkg::*;
#(
    parameter int unsigned N                 = N_DEF,
    parameter int unsigned DW                = DW_DEF,
    parameter int unsigned CELLS             = N * N,
    parameter int unsigned IW                = IW_DEF,
    parameter int unsigned MAX_STRIKES       = MAX_STRIKES_DEF,
    parameter int unsigned SW                = 2,
    parameter logic [2:0]  CARREGANDO        = ST_CARREGANDO,
    parameter logic [2:0]  PERCORRER_NUMEROS = ST_PERCORRER_NUMEROS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_button,
    input  logic                  down_button,
    input  logic                  a_button,
    input  logic                  b_button,
    input  logic [IW-1:0]         index,
    input  logic [DW-1:0]         cell_value,
    input  logic [2:0]            current_state,
    input  logic [CELLS-1:0]      selected_visibility,
    input  logic [CELLS*DW-1:0]   selected_map,
    output logic [CELLS-1:0]      visibilities,
    output logic [CELLS*DW-1:0]   board,
    output logic [CELLS*N-1:0]    notes,
    output logic                  note_mode,
    output logic                  error,
    output logic [SW-1:0]         strikes,
    output logic [DW-1:0]         selected_number,
    output logic [IW-1:0]         revealed_count,
    output logic                  game_won,
    output logic                  game_over
);

    localparam int unsigned    PW      = $clog2(CELLS + 1);
    localparam logic [DW-1:0]  N_D     = DW'(N);
    localparam logic [DW-1:0]  ONE_D   = DW'(1);
    localparam logic [IW-1:0]  CELLS_I = IW'(CELLS);
    localparam logic [IW-1:0]  ONE_I   = IW'(1);
    localparam logic [SW-1:0]  MAX_S   = SW'(MAX_STRIKES);
    localparam logic [SW-1:0]  ONE_S   = SW'(1);

    logic [CELLS-1:0]    vis_q, vis_d;
    logic [CELLS*DW-1:0] board_q, board_d;
    logic [CELLS*N-1:0]  notes_q, notes_d;
    logic                note_mode_q, note_mode_d;
    logic                error_q, error_d;
    logic [SW-1:0]       strikes_q, strikes_d;
    logic [DW-1:0]       sel_q, sel_d;
    logic [IW-1:0]       count_q, count_d;
    logic                won_q, won_d;
    logic                over_q, over_d;
    logic [PW-1:0]       load_count;

    popcount #(.W(CELLS)) u_popcount (
        .bits_i  (selected_visibility),
        .count_o (load_count)
    );

    always_comb begin
        vis_d       = vis_q;
        board_d     = board_q;
        notes_d     = notes_q;
        note_mode_d = note_mode_q;
        error_d     = error_q;
        strikes_d   = strikes_q;
        sel_d       = sel_q;
        count_d     = count_q;

        if (current_state == CARREGANDO) begin
            vis_d       = selected_visibility;
            board_d     = selected_map;
            notes_d     = '0;
            note_mode_d = 1'b0;
            error_d     = 1'b0;
            strikes_d   = '0;
            count_d     = IW'(load_count);
        end else if (current_state == PERCORRER_NUMEROS && !won_q && !over_q) begin
            if (up_button || down_button || a_button || b_button) begin
                error_d = 1'b0;
            end
            if (up_button) begin
                sel_d = (sel_q >= N_D) ? ONE_D : sel_q + ONE_D;
            end else if (down_button) begin
                sel_d = (sel_q <= ONE_D) ? N_D : sel_q - ONE_D;
            end
            if (b_button) begin
                note_mode_d = ~note_mode_q;
            end
            // The commit reads sel_q/note_mode_q so same-cycle up/down/b only affect later commits.
            if (a_button && index < CELLS_I) begin
                for (int unsigned c = 0; c < CELLS; c++) begin
                    if (index == IW'(c) && !vis_q[c]) begin
                        if (note_mode_q) begin
                            for (int unsigned d = 0; d < N; d++) begin
                                if (sel_q == DW'(d + 1)) begin
                                    notes_d[c*N+d] = ~notes_q[c*N+d];
                                end
                            end
                        end else if (cell_value == sel_q) begin
                            vis_d[c]         = 1'b1;
                            notes_d[c*N +: N] = '0;
                            count_d          = count_q + ONE_I;
                        end else begin
                            error_d = 1'b1;
                            if (strikes_q != MAX_S) begin
                                strikes_d = strikes_q + ONE_S;
                            end
                        end
                    end
                end
            end
        end

        won_d  = (count_d == CELLS_I);
        over_d = (strikes_d == MAX_S);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis_q       <= '0;
            board_q     <= '0;
            notes_q     <= '0;
            note_mode_q <= 1'b0;
            error_q     <= 1'b0;
            strikes_q   <= '0;
            sel_q       <= ONE_D;
            count_q     <= '0;
            won_q       <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            vis_q       <= vis_d;
            board_q     <= board_d;
            notes_q     <= notes_d;
            note_mode_q <= note_mode_d;
            error_q     <= error_d;
            strikes_q   <= strikes_d;
            sel_q       <= sel_d;
            count_q     <= count_d;
            won_q       <= won_d;
            over_q      <= over_d;
        end
    end

    assign visibilities    = vis_q;
    assign board           = board_q;
    assign notes           = notes_q;
    assign note_mode       = note_mode_q;
    assign error           = error_q;
    assign strikes         = strikes_q;
    assign selected_number = sel_q;
    assign revealed_count  = count_q;
    assign game_won        = won_q;
    assign game_over       = over_q;

endmodule
